// File: rtl/shift_normalizer_if.sv
// Handshake bundle for shift_normalizer: an input word channel
// (valid/ready/data/mode) and a result channel (valid/ready/data/shift/zero).
// The slave modport is the normalizer; the master modport is its producer/consumer.
interface shift_normalizer_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_lr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SHW-1:0]   out_shift;
    logic             out_zero;

    modport master (
        output in_valid,
        output in_data,
        output in_lr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_shift,
        input  out_zero
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_lr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_shift,
        output out_zero
    );
endinterface

// File: rtl/shift_normalizer.sv
// shift_normalizer: recovers the shift amount that aligns a word.
//   in_lr = 0 : count leading zeros, left-align so the MSB is 1.
//   in_lr = 1 : count trailing zeros, right-align so the LSB is 1.
// out_shift together with the mode bit can drive the downstream barrel
// shifter directly. An all-zero word reports out_zero with shift 0.
//
// Build option SHIFT_NORM_FAST_EN:
//   undefined - iterative scan, one bit position per cycle (IDLE/SCAN/HOLD).
//   defined   - single-cycle priority encoder + combinational shift,
//               IDLE goes straight to HOLD for every word.
module shift_normalizer #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic                clk,
    input  logic                rst,
    shift_normalizer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_out_data;
    logic [SHW-1:0]   r_out_shift;
    logic             r_out_zero;

    logic             w_accept;
    logic             w_in_zero;

    assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
    assign w_in_zero = (bus.in_data == '0);

`ifdef SHIFT_NORM_FAST_EN
    // Leading-zero count: the highest set bit is the last one visited.
    function automatic logic [SHW-1:0] lead_zeros(input logic [WIDTH-1:0] d);
        logic [SHW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) c = SHW'(WIDTH - 1 - i);
        end
        return c;
    endfunction

    // Trailing-zero count: the lowest set bit is the last one visited.
    function automatic logic [SHW-1:0] trail_zeros(input logic [WIDTH-1:0] d);
        logic [SHW-1:0] c;
        c = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (d[i]) c = SHW'(i);
        end
        return c;
    endfunction

    logic [SHW-1:0]   w_fast_cnt;
    logic [WIDTH-1:0] w_fast_data;

    // Count and align the incoming word in one pass; zero input yields 0/0.
    always_comb begin
        w_fast_cnt  = bus.in_lr ? trail_zeros(bus.in_data) : lead_zeros(bus.in_data);
        w_fast_data = bus.in_lr ? (bus.in_data >> w_fast_cnt)
                                : (bus.in_data << w_fast_cnt);
    end
`else
    logic [WIDTH-1:0] r_work;
    logic             r_mode;
    logic [SHW-1:0]   r_cnt;
    logic             w_lead;

    // Bit that decides whether the word is already aligned in the current mode.
    assign w_lead = r_mode ? r_work[0] : r_work[WIDTH-1];

    // Working copy of the word: loaded on accept, shifted one place per SCAN
    // cycle until the lead bit is set. Nonzero words stop within WIDTH-1 shifts,
    // so the count cannot wrap.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_work <= bus.in_data;
            r_mode <= bus.in_lr;
            r_cnt  <= '0;
        end else if ((r_state == ST_SCAN) && !w_lead) begin
            r_work <= r_mode ? (r_work >> 1) : (r_work << 1);
            r_cnt  <= r_cnt + SHW'(1);
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
`ifdef SHIFT_NORM_FAST_EN
                    w_state_nxt = ST_HOLD;
`else
                    w_state_nxt = w_in_zero ? ST_HOLD : ST_SCAN;
`endif
                end
            end
            ST_SCAN: begin
`ifdef SHIFT_NORM_FAST_EN
                w_state_nxt = ST_IDLE;
`else
                if (w_lead) w_state_nxt = ST_HOLD;
`endif
            end
            ST_HOLD: begin
                if (bus.out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Result registers: written once per word, held through HOLD and kept
    // after the handshake until the next result overwrites them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_shift <= '0;
            r_out_zero  <= 1'b0;
        end else begin
`ifdef SHIFT_NORM_FAST_EN
            if (w_accept) begin
                r_out_data  <= w_fast_data;
                r_out_shift <= w_fast_cnt;
                r_out_zero  <= w_in_zero;
            end
`else
            if (w_accept && w_in_zero) begin
                r_out_data  <= '0;
                r_out_shift <= '0;
                r_out_zero  <= 1'b1;
            end else if ((r_state == ST_SCAN) && w_lead) begin
                r_out_data  <= r_work;
                r_out_shift <= r_cnt;
                r_out_zero  <= 1'b0;
            end
`endif
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.out_data  = r_out_data;
    assign bus.out_shift = r_out_shift;
    assign bus.out_zero  = r_out_zero;

endmodule

// File: tb/tb_shift_normalizer.sv
// Self-checking bench for shift_normalizer: directed corner words followed by
// a randomized sweep of every 8-bit word in both modes, compared against a
// reference computed from bit-position arithmetic.
module tb_shift_normalizer;
    localparam int WIDTH = 8;
    localparam int SHW   = 3;
`ifdef SHIFT_NORM_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    shift_normalizer_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    shift_normalizer #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: position of the highest / lowest set bit via log2.
    function automatic void ref_norm(input logic [7:0] d, input logic lr,
                                     output logic [7:0] od, output int k, output bit z);
        int dv;
        int lsb;
        dv = int'(d);
        z  = (dv == 0);
        if (z) begin
            od = 8'h00;
            k  = 0;
        end else if (!lr) begin
            k  = 8 - $clog2(dv + 1);
            od = 8'((dv << k) & 255);
        end else begin
            lsb = dv & (-dv);
            k   = $clog2(lsb);
            od  = 8'(dv >> k);
        end
    endfunction

    // Offer one word at a negedge, measure latency, check result, then
    // stall the consumer for 'hold' cycles before accepting the result.
    task automatic run_word(input logic [7:0] d, input logic lr, input int hold);
        logic [7:0] ed;
        int         ek;
        bit         ez;
        int         elat;
        int         n;
        logic [7:0] rec;
        ref_norm(d, lr, ed, ek, ez);
        elat = (ez || FAST) ? 1 : ek + 2;

        check_val("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_lr     = lr;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_lr    = 1'($urandom);

        @(negedge clk);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("latency", 32'(n + 1), 32'(elat));
        check_val("out_data", 32'(bus.out_data), 32'(ed));
        check_val("out_shift", 32'(bus.out_shift), 32'(ek));
        check_val("out_zero", 32'(bus.out_zero), 32'(ez));
        check_val("in_ready_busy", 32'(bus.in_ready), 32'd0);
        if (!ez) begin
            rec = lr ? 8'(bus.out_data << bus.out_shift) : 8'(bus.out_data >> bus.out_shift);
            check_val("invariant", 32'(rec), 32'(d));
        end

        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            bus.in_lr    = 1'($urandom);
            @(negedge clk);
            check_val("hold_valid", 32'(bus.out_valid), 32'd1);
            check_val("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check_val("hold_data", 32'(bus.out_data), 32'(ed));
            check_val("hold_shift", 32'(bus.out_shift), 32'(ek));
            check_val("hold_zero", 32'(bus.out_zero), 32'(ez));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        @(negedge clk);
        check_val("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("post_hs_valid", 32'(bus.out_valid), 32'd0);
        check_val("post_hs_data", 32'(bus.out_data), 32'(ed));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mask;
        int         stray;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_lr     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_out_data", 32'(bus.out_data), 32'd0);
        check_val("rst_out_shift", 32'(bus.out_shift), 32'd0);
        check_val("rst_out_zero", 32'(bus.out_zero), 32'd0);

        // Directed corner words.
        run_word(8'h10, 1'b0, 0);
        run_word(8'h0C, 1'b1, 0);
        run_word(8'h80, 1'b0, 0);
        run_word(8'h00, 1'b0, 0);
        run_word(8'h00, 1'b1, 1);
        run_word(8'h01, 1'b0, 4);
        run_word(8'h80, 1'b1, 0);
        run_word(8'hFF, 1'b1, 0);

        // Reset while a word is in flight (mid-SCAN, or HOLD in the fast build).
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h02;
        bus.in_lr     = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("midrst_out_data", 32'(bus.out_data), 32'd0);
        check_val("midrst_out_shift", 32'(bus.out_shift), 32'd0);
        check_val("midrst_out_zero", 32'(bus.out_zero), 32'd0);
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        check_val("midrst_no_valid", 32'(stray), 32'd0);
        run_word(8'h40, 1'b0, 0);

        // Every word in both modes, random visiting order and random stalls.
        mask = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            for (int m = 0; m < 2; m++) begin
                run_word(8'(i) ^ mask, 1'(m), int'($urandom_range(0, 2)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/shift_normalizer.md
# shift_normalizer

Sequential normalizer that finds the shift amount that aligns an 8-bit word, and returns that amount with the aligned word. It runs in the opposite direction to the team's pre/post-reversal barrel shifter: the shifter applies a given shift, and this block recovers the shift amount. Left mode counts leading zeros and left-aligns the word so the MSB is 1. Right mode counts trailing zeros and right-aligns it so the LSB is 1. It sits upstream of the barrel shifter in the datapath, and its `out_shift`/direction pair can drive the shifter directly.

## Interface
- `WIDTH`, 8: data width (the bench targets 8 only).
- `SHW`, 3: shift-count width, equal to log2(`WIDTH`).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: input word offered.
- `in_ready` output 1: block can accept a word; high only in IDLE.
- `in_data` input `WIDTH`: word to normalize.
- `in_lr` input 1: 1 = right-normalize (trailing zeros), 0 = left-normalize (leading zeros).
- `out_valid` output 1: result held.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output `WIDTH`: aligned word.
- `out_shift` output `SHW`: zero count, i.e. the logical shift applied.
- `out_zero` output 1: input word was all zeros.

## Operation
- FSM states: IDLE, SCAN, HOLD. After reset the FSM is in IDLE.
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_shift`=0, `out_zero`=0.
- **IDLE:**
  - Accept when `in_valid && in_ready`.
  - On accept, latch `in_data` into the work register, latch `in_lr` into the mode bit, and clear the count.
  - If `in_data`==0: set `out_zero`=1, `out_shift`=0 and `out_data`=0, then go to HOLD.
  - Otherwise go to SCAN.
- **SCAN:** each cycle, test the lead bit (bit `WIDTH`-1 in left mode, bit 0 in right mode).
  - Lead bit 1: copy the work register to `out_data` and the count to `out_shift`, set `out_zero`=0, then go to HOLD.
  - Lead bit 0: shift the work register one place (left in left mode, right in right mode), zero-fill, and increment the count.
  - For nonzero inputs the count never exceeds `WIDTH`-1, so no saturation logic is needed.
- **HOLD:**
  - `out_valid`=1 and `in_ready`=0.
  - `out_data`, `out_shift` and `out_zero` stay stable until `out_valid && out_ready`.
  - On that handshake, go to IDLE and drop `out_valid` on the next cycle.
  - Output values persist after the handshake until they are overwritten.
- Input is ignored outside IDLE. `in_data` and `in_lr` are sampled only on the accept edge.
- **Invariant for nonzero inputs:** logically shifting `out_data` by `out_shift`, opposite to `in_lr`, reproduces `in_data`. The shifted-out positions must be zero.
- `rst` in any state (mid-SCAN or mid-HOLD) returns the FSM to IDLE with the reset values on the next edge. A pending result is discarded.

## Timing
- Accept at edge A, for a nonzero input with zero count k:
  - SCAN lasts k+1 cycles.
  - `out_valid` rises at edge A+k+2.
- Zero input: `out_valid` rises at edge A+1.
- Worst case: 0x01 in left mode, or 0x80 in right mode, gives k=7 and `out_valid` at A+9.
- If `out_ready` is high when `out_valid` rises, the result handshakes in that cycle. `in_ready` rises on the following edge.
- Throughput is at most one word per k+3 cycles. There is no overlap between consecutive words.

## Configuration
- `SHIFT_NORM_FAST_EN` defined:
  - SCAN is never entered.
  - On accept, a combinational priority encoder computes the count, and the aligned word is formed by a single combinational shift.
  - Both go directly to HOLD, so `out_valid` rises at A+1 for every input.
  - Outputs, HOLD behaviour and reset behaviour are unchanged.
- `SHIFT_NORM_FAST_EN` undefined: the iterative one-bit-per-cycle SCAN described above.

## Test plan
- 0x10 in left mode, `out_ready`=1 → `out_data`=0x80, `out_shift`=3, `out_zero`=0, `out_valid` at A+5, `in_ready` back high at A+6.
- 0x0C in right mode → `out_data`=0x03, `out_shift`=2, `out_valid` at A+4. Also 0x80 in left mode → `out_shift`=0, `out_valid` at A+2.
- 0x00 in either mode → `out_zero`=1, `out_shift`=0, `out_data`=0x00, `out_valid` at A+1.
- 0x01 in left mode with `out_ready` held low for 4 cycles after `out_valid` → `out_data`=0x80, `out_shift`=7, outputs stable and `in_ready`=0 throughout. A new `in_valid` offered during HOLD is ignored.
- 0x02 in left mode, `rst` pulsed at A+3 (mid-SCAN) → IDLE at the next edge, all outputs at their reset values, no `out_valid`. The next word, 0x40 in left mode, gives `out_shift`=1.
- With `SHIFT_NORM_FAST_EN` defined, 0x01 in left mode → `out_shift`=7 and `out_data`=0x80 at A+1. Random sweep of all 256 inputs × both modes checks the invariant.
